// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register: reset level, occupancy
// state encodings and the zero word driven on bubbles.
package if_id_stage_pkg;

  // Active level of the asynchronous reset.
  localparam logic RstEnable = 1'b1;

  // Number of entries held by the stage; the value doubles as the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Bubble payload; sliced down to the width actually needed.
  localparam int unsigned ZeroWordW = 256;
  localparam logic [ZeroWordW-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with main and skid storage.
// Optional feature macro: IF_ID_SKID_EN (two-entry skid, registered in_ready).
// Without it only the main register exists and in_ready is combinational
// from out_ready.
module pipe_skid_reg
  import if_id_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  occ_e              r_state, w_state_d;
  logic [DATA_W-1:0] r_main, w_main_d;
  logic              w_in_xfer, w_out_xfer;
`ifdef IF_ID_SKID_EN
  logic [DATA_W-1:0] r_skid, w_skid_d;
`endif

  assign out_valid = (r_state != OCC_EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

`ifdef IF_ID_SKID_EN
  // Depends only on registered state (and reset), so no path from out_ready.
  assign in_ready = (rst != RstEnable) && (r_state != OCC_TWO);
`else
  assign in_ready = (rst != RstEnable) && (out_ready || !out_valid);
`endif

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Next-state and storage update; flush overrides every transfer.
  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
`ifdef IF_ID_SKID_EN
    w_skid_d  = r_skid;
`endif
    if (flush) begin
      // Main keeps its value so a non-zeroed bubble still shows the last pair.
      w_state_d = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_xfer) begin
            w_main_d  = in_data;
            w_state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
`ifdef IF_ID_SKID_EN
          if (w_in_xfer && w_out_xfer) begin
            w_main_d = in_data;
          end else if (w_in_xfer) begin
            w_skid_d  = in_data;
            w_state_d = OCC_TWO;
          end else if (w_out_xfer) begin
            w_state_d = OCC_EMPTY;
          end
`else
          // Here an input transfer implies an output transfer in the same cycle.
          if (w_in_xfer) begin
            w_main_d = in_data;
          end else if (w_out_xfer) begin
            w_state_d = OCC_EMPTY;
          end
`endif
        end
        OCC_TWO: begin
`ifdef IF_ID_SKID_EN
          if (w_out_xfer) begin
            w_main_d  = r_skid;
            w_state_d = OCC_ONE;
          end
`else
          w_state_d = OCC_EMPTY;
`endif
        end
        default: w_state_d = OCC_EMPTY;
      endcase
    end
  end

  // State and storage registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state <= OCC_EMPTY;
      r_main  <= '0;
`ifdef IF_ID_SKID_EN
      r_skid  <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_main  <= w_main_d;
`ifdef IF_ID_SKID_EN
      r_skid  <= w_skid_d;
`endif
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: packs PC and instruction into one payload, holds it
// in pipe_skid_reg and optionally zeroes the presented payload on bubbles.
// Optional feature macro: IF_ID_SKID_EN (forwarded to pipe_skid_reg).
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned ZERO_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  localparam int unsigned DataW = PC_W + INST_W;

  logic [DataW-1:0] w_in_data;
  logic [DataW-1:0] w_out_data;
  logic             w_show;

  assign w_in_data = {in_pc, in_inst};

  pipe_skid_reg #(
    .DATA_W (DataW)
  ) u_pipe_skid_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data),
    .occupancy (occupancy)
  );

  // Payload is visible while valid, or always when bubbles are not zeroed.
  assign w_show   = out_valid || (ZERO_BUBBLE == 0);
  assign out_pc   = w_show ? w_out_data[DataW-1:INST_W] : ZERO_WORD[PC_W-1:0];
  assign out_inst = w_show ? w_out_data[INST_W-1:0]     : ZERO_WORD[INST_W-1:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver pushes accepted pairs, a negedge
// monitor compares whatever the DUT presents against the queue head.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [1:0]  occupancy;
  logic        h_in_ready, h_out_valid;
  logic [31:0] h_out_pc, h_out_inst;
  logic [1:0]  h_occupancy;

  if_id_stage #(.PC_W(32), .INST_W(32), .ZERO_BUBBLE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .occupancy(occupancy)
  );

  // Second instance that holds the last pair on bubbles.
  if_id_stage #(.PC_W(32), .INST_W(32), .ZERO_BUBBLE(0)) dut_hold (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_pc(h_out_pc), .out_inst(h_out_inst), .occupancy(h_occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          lat_mode = 1'b0;
  int          occ_max = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_inst = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare presented pair with the queue head, pop on consumption.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_pc   = '0;
      last_inst = '0;
    end else begin
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      chk("occ_vs_valid", {63'b0, out_valid}, {63'b0, occupancy != 2'd0});
      chk("hold_valid", {63'b0, h_out_valid}, {63'b0, out_valid});
`ifdef IF_ID_SKID_EN
      chk("in_ready_reg", {63'b0, in_ready}, {63'b0, occupancy != 2'd2});
`else
      chk("in_ready_comb", {63'b0, in_ready}, {63'b0, out_ready | ~out_valid});
      chk("occ_le_1", {63'b0, occupancy <= 2'd1}, 64'd1);
`endif
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_pc", {32'b0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("out_pc", {32'b0, out_pc}, {32'b0, sb[0].pc});
          chk("out_inst", {32'b0, out_inst}, {32'b0, sb[0].inst});
          chk("hold_inst_valid", {32'b0, h_out_inst}, {32'b0, sb[0].inst});
          if (lat_mode) chk("latency", 64'(cyc), 64'(sb[0].cyc + 1));
          if (out_ready) void'(sb.pop_front());
        end
        last_pc   = out_pc;
        last_inst = out_inst;
      end else begin
        chk("bubble_pc", {32'b0, out_pc}, 64'd0);
        chk("bubble_inst", {32'b0, out_inst}, 64'd0);
        chk("hold_pc", {32'b0, h_out_pc}, {32'b0, last_pc});
        chk("hold_inst", {32'b0, h_out_inst}, {32'b0, last_inst});
      end
      if (flush) sb.delete();
    end
  end

  // Offer one pair and wait (bounded) for acceptance; expected value queued on accept.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush) sb.push_back('{pc: pc, inst: inst, cyc: cyc});
        done = 1'b1;
      end
    end
    if (!done) chk("send_accept", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    idle(2);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_occ", {62'b0, occupancy}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    idle(1);

    // Streaming: 8 pairs, one per cycle, 1-cycle latency
    lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    idle(3);
    lat_mode = 1'b0;
    chk("drain_valid", {63'b0, out_valid}, 64'd0);
    chk("zero_bubble_pc", {32'b0, out_pc}, 64'd0);
    chk("zero_bubble_inst", {32'b0, out_inst}, 64'd0);
    chk("held_pc", {32'b0, h_out_pc}, 64'h11C);
    chk("held_inst", {32'b0, h_out_inst}, 64'hC0DE_0007);

    // Backpressure: out_ready low for 3 cycles mid-stream
    occ_max = 0;
    fork
      for (int i = 0; i < 6; i++) send(32'h200 + 32'(4 * i), 32'hBEEF_0000 + 32'(i));
      begin
        idle(2);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(4);
`ifdef IF_ID_SKID_EN
    chk("bp_occ_max", 64'(occ_max), 64'd2);
`else
    chk("bp_occ_max", 64'(occ_max), 64'd1);
`endif

    // Flush while full (or stalled) with a same-cycle input
    out_ready = 1'b0;
    send(32'h300, 32'h0000_0300);
`ifdef IF_ID_SKID_EN
    send(32'h304, 32'h0000_0304);
    chk("pre_flush_occ", {62'b0, occupancy}, 64'd2);
`else
    chk("pre_flush_occ", {62'b0, occupancy}, 64'd1);
`endif
    in_valid = 1'b1;
    in_pc    = 32'hDEAD_0000;
    in_inst  = 32'hDEAD_0001;
    flush    = 1'b1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_occ", {62'b0, occupancy}, 64'd0);
    out_ready = 1'b1;
    idle(3);

    // Flush with a same-cycle output transfer and an acceptable input
    send(32'h400, 32'h0000_0400);
    chk("pre_flush2_in_ready", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_pc    = 32'h404;
    in_inst  = 32'h0000_0404;
    flush    = 1'b1;
    idle(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", {63'b0, out_valid}, 64'd0);
    chk("flush2_occ", {62'b0, occupancy}, 64'd0);
    idle(4);

    // in_ready dependence on out_ready with one entry held
    out_ready = 1'b0;
    send(32'h500, 32'h0000_0500);
    chk("one_occ", {62'b0, occupancy}, 64'd1);
`ifdef IF_ID_SKID_EN
    chk("one_in_ready_stall", {63'b0, in_ready}, 64'd1);
`else
    chk("one_in_ready_stall", {63'b0, in_ready}, 64'd0);
`endif
    out_ready = 1'b1;
    #1;
    chk("one_in_ready_go", {63'b0, in_ready}, 64'd1);
    idle(3);

    // Reset asserted mid-stream with held data and a pending offer
    out_ready = 1'b0;
    send(32'h600, 32'h0000_0600);
    in_valid = 1'b1;
    in_pc    = 32'h604;
    in_inst  = 32'h0000_0604;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_pc", {32'b0, out_pc}, 64'd0);
    chk("mid_rst_inst", {32'b0, out_inst}, 64'd0);
    chk("mid_rst_occ", {62'b0, occupancy}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("mid_rst_hold_pc", {32'b0, h_out_pc}, 64'd0);
    idle(1);
    in_valid = 1'b0;
    idle(1);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rel_valid", {63'b0, out_valid}, 64'd0);
    out_ready = 1'b1;
    idle(4);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
